// File: rtl/trap_pkg.sv
// Shared state encoding, cause codes and mstatus bit positions for the trap sequencer.
package trap_pkg;

   typedef enum logic [2:0] {
      IDLE,
      T_STAT,
      T_JUMP,
      R_STAT,
      R_JUMP
   } trap_state_t;

   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;
   localparam logic [3:0] CAUSE_MEI = 4'd11;

   localparam int MIE  = 3;
   localparam int MPIE = 7;

   localparam logic [31:0] MSTATUS_ADDR_DEFAULT = 32'h0000_0C00;

endpackage

// File: rtl/trap_ctrl_if.sv
// Core/CSR-file side signals of the trap sequencer; master is the core and CSR file, slave is trap_ctrl.
interface trap_ctrl_if;

   logic [31:0] mstatus;
   logic [31:0] mie;
   logic [31:0] mtvec;
   logic        time_compare;
   logic        sw_irq;
   logic        ext_irq;
   logic        exc_valid;
   logic [3:0]  exc_code;
   logic [31:0] exc_tval;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        instr_done;
   logic        mret;

   logic [31:0] mip;
   logic [31:0] mcause;
   logic [31:0] mepc;
   logic [31:0] mbadaddr;
   logic        csr_write_en;
   logic [31:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;

   modport master (
      output mstatus, mie, mtvec, time_compare, sw_irq, ext_irq,
             exc_valid, exc_code, exc_tval, pc, next_pc, instr_done, mret,
      input  mip, mcause, mepc, mbadaddr, csr_write_en, csr_addr, csr_wdata,
             redirect, redirect_pc, stall
   );

   modport slave (
      input  mstatus, mie, mtvec, time_compare, sw_irq, ext_irq,
             exc_valid, exc_code, exc_tval, pc, next_pc, instr_done, mret,
      output mip, mcause, mepc, mbadaddr, csr_write_en, csr_addr, csr_wdata,
             redirect, redirect_pc, stall
   );

endinterface

// File: rtl/trap_irq_sel.sv
// Combinational interrupt priority encoder: MEI over MSI over MTI, gated by mstatus.MIE.
module trap_irq_sel
   import trap_pkg::*;
(
   input  logic [31:0] mie,
   input  logic [31:0] mip,
   input  logic        mstatus_mie,
   output logic        irq_valid,
   output logic [3:0]  cause
);

   logic [31:0] active;

   always_comb begin
      active    = mie & mip;
      irq_valid = mstatus_mie && (active != 32'h0);
      cause     = CAUSE_MTI;
      if (active[CAUSE_MEI]) begin
         cause = CAUSE_MEI;
      end else if (active[CAUSE_MSI]) begin
         cause = CAUSE_MSI;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: latches trap state, rewrites mstatus and redirects fetch.
// Define TRAP_VECTORED_EN to vector interrupts to base + 4*cause when mtvec[1:0] = 01.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int          XLEN         = 32,
   parameter logic [31:0] MSTATUS_ADDR = MSTATUS_ADDR_DEFAULT
) (
   input logic        clk,
   input logic        resetn,
   trap_ctrl_if.slave bus
);

   trap_state_t     state;
   trap_state_t     state_next;
   logic            irq_valid;
   logic [3:0]      irq_cause;
   logic            take_exc;
   logic            take_trap;
   logic            take_mret;
   logic [XLEN-1:0] trap_target;

   trap_irq_sel u_irq_sel (
      .mie         (bus.mie),
      .mip         (bus.mip),
      .mstatus_mie (bus.mstatus[MIE]),
      .irq_valid   (irq_valid),
      .cause       (irq_cause)
   );

   // Exceptions outrank interrupts, and any trap outranks an mret in the same cycle.
   assign take_exc  = (state == IDLE) && bus.exc_valid;
   assign take_trap = take_exc || ((state == IDLE) && irq_valid && bus.instr_done);
   assign take_mret = (state == IDLE) && !take_trap && bus.mret;

   always_comb begin
      trap_target = bus.mtvec & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
      if (bus.mcause[31] && (bus.mtvec[1:0] == 2'b01)) begin
         trap_target = (bus.mtvec & 32'hFFFF_FFFC) + {26'b0, bus.mcause[3:0], 2'b00};
      end
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         bus.mip      <= '0;
         bus.mcause   <= '0;
         bus.mepc     <= '0;
         bus.mbadaddr <= '0;
      end else begin
         state   <= state_next;
         bus.mip <= {20'b0, bus.ext_irq, 3'b0, bus.time_compare, 3'b0, bus.sw_irq, 3'b0};
         if (take_exc) begin
            bus.mcause   <= {28'b0, bus.exc_code};
            bus.mepc     <= bus.pc;
            bus.mbadaddr <= bus.exc_tval;
         end else if (take_trap) begin
            bus.mcause   <= {1'b1, 27'b0, irq_cause};
            bus.mepc     <= bus.next_pc;
            bus.mbadaddr <= '0;
         end
      end
   end

   always_comb begin
      state_next       = state;
      bus.csr_write_en = 1'b0;
      bus.csr_addr     = '0;
      bus.csr_wdata    = '0;
      bus.redirect     = 1'b0;
      bus.redirect_pc  = '0;
      bus.stall        = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (take_trap) begin
               state_next = T_STAT;
               bus.stall  = 1'b1;
            end else if (take_mret) begin
               state_next = R_STAT;
               bus.stall  = 1'b1;
            end
         end
         T_STAT: begin
            bus.csr_write_en    = 1'b1;
            bus.csr_addr        = MSTATUS_ADDR;
            bus.csr_wdata       = bus.mstatus;
            bus.csr_wdata[MPIE] = bus.mstatus[MIE];
            bus.csr_wdata[MIE]  = 1'b0;
            state_next          = T_JUMP;
         end
         T_JUMP: begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = trap_target;
            state_next      = IDLE;
         end
         R_STAT: begin
            bus.csr_write_en    = 1'b1;
            bus.csr_addr        = MSTATUS_ADDR;
            bus.csr_wdata       = bus.mstatus;
            bus.csr_wdata[MIE]  = bus.mstatus[MPIE];
            bus.csr_wdata[MPIE] = 1'b1;
            state_next          = R_JUMP;
         end
         R_JUMP: begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = bus.mepc;
            state_next      = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer for the machine-mode CSR file. It samples interrupt sources and core exceptions and produces the trap-state values the CSR file mirrors: mip, mcause, mepc and mbadaddr. It updates mstatus MIE/MPIE through the CSR write port and redirects fetch on trap entry and on mret. It sits between the core pipeline and the CSR file and is the only writer of trap state.

## Interface
Parameters:
- XLEN, 32, data width; only 32 is supported.
- MSTATUS_ADDR, 32'h0000_0C00, byte address driven on `csr_addr` for mstatus writes (word index 0x300).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- mstatus  in  32  current mstatus from the CSR file; bit 3 is MIE, bit 7 is MPIE.
- mie  in  32  interrupt enables from the CSR file.
- mtvec  in  32  trap vector from the CSR file.
- time_compare  in  1  timer interrupt level.
- sw_irq  in  1  software interrupt level.
- ext_irq  in  1  external interrupt level.
- exc_valid  in  1  synchronous exception request, one-cycle pulse.
- exc_code  in  4  exception cause code.
- exc_tval  in  32  faulting address or value for the exception.
- pc  in  32  PC of the current instruction.
- next_pc  in  32  PC of the next instruction.
- instr_done  in  1  instruction retire boundary.
- mret  in  1  mret executed, one-cycle pulse.
- mip  out  32  pending interrupts; bit 3 MSIP, bit 7 MTIP, bit 11 MEIP, all other bits 0.
- mcause  out  32  trap cause; bit 31 set for interrupts.
- mepc  out  32  trap return PC.
- mbadaddr  out  32  trap value.
- csr_write_en  out  1  CSR write strobe.
- csr_addr  out  32  CSR write address.
- csr_wdata  out  32  CSR write data.
- redirect  out  1  fetch redirect, one-cycle pulse.
- redirect_pc  out  32  redirect target.
- stall  out  1  holds the core while a trap or return sequence runs.

## Operation
- `mip` is registered every cycle from the interrupt levels: {ext_irq→bit 11, time_compare→bit 7, sw_irq→bit 3}.
- An interrupt is pending when mstatus[3]=1 and (mie & mip)!=0. Pending interrupts are accepted only in IDLE and only when instr_done=1.
- An exception is accepted in IDLE on any cycle with exc_valid=1.
- Acceptance priority: exception, then MEI (cause 11), then MSI (cause 3), then MTI (cause 7).
- If an exception and mret arrive in the same cycle, the exception wins and the mret is dropped.
- Trap acceptance latches the trap registers in the same edge:
  - Exception: mcause={28'b0,exc_code}, mepc=pc, mbadaddr=exc_tval.
  - Interrupt: mcause={1'b1,27'b0,cause}, mepc=next_pc, mbadaddr=0.
- mret acceptance (IDLE, mret=1, no exception) changes no trap register.
- FSM states and transitions:
  - IDLE: → T_STAT on an accepted trap; → R_STAT on an accepted mret.
  - T_STAT: csr_write_en=1, csr_addr=MSTATUS_ADDR, csr_wdata=mstatus with bit 7 set to mstatus[3] and bit 3 cleared. → T_JUMP.
  - T_JUMP: redirect=1, redirect_pc=trap target. → IDLE.
  - R_STAT: csr_wdata=mstatus with bit 3 set to mstatus[7] and bit 7 set to 1. → R_JUMP.
  - R_JUMP: redirect=1, redirect_pc=mepc. → IDLE.
- `stall` = (state≠IDLE) | (IDLE & an event is accepted this cycle). It is combinational.
- All requests are ignored outside IDLE. Interrupt levels stay visible in mip and are re-evaluated on return to IDLE.

## Timing
- Reset values: mip, mcause, mepc, mbadaddr, csr_addr, csr_wdata and redirect_pc are 0; csr_write_en, redirect and stall are 0; state is IDLE.
- Trap accepted in cycle N:
  - Trap registers are valid from cycle N+1.
  - mstatus write occurs in cycle N+1.
  - redirect occurs in cycle N+2.
  - stall is high in cycles N to N+2.
- mip lags its inputs by one cycle.
- Reset asserted mid-sequence aborts the sequence immediately: no write and no redirect are issued, and all outputs return to their reset values.
- Vector arithmetic is modulo 2^32; base+4*cause wraps silently.

## Configuration
- TRAP_VECTORED_EN defined: when mtvec[1:0]=01 and the trap is an interrupt, the target is {mtvec[31:2],2'b00}+(cause<<2). Exceptions always use the base.
- TRAP_VECTORED_EN undefined: the target is always {mtvec[31:2],2'b00}; mtvec[1:0] is ignored.

## Structure
- Package `trap_pkg` holds:
  - the state enum (IDLE, T_STAT, T_JUMP, R_STAT, R_JUMP);
  - cause constants CAUSE_MSI=3, CAUSE_MTI=7, CAUSE_MEI=11;
  - mstatus bit positions MIE=3, MPIE=7;
  - the MSTATUS_ADDR default.
- One sub-module, `trap_irq_sel`: a combinational priority encoder taking mie, mip and MIE and producing irq_valid and a 4-bit cause.

## Test plan
- Exception path: exc_valid with exc_code=2, pc=0x100, exc_tval=0xDEAD, mtvec=0x200, mstatus=0x8 →
  - N+1: mcause=2, mepc=0x100, mbadaddr=0xDEAD, csr_wdata=0x80;
  - N+2: redirect to 0x200.
- Vectored timer interrupt with TRAP_VECTORED_EN, mtvec=0x201, mie=0x80, time_compare=1, instr_done=1, next_pc=0x44 → mcause=0x8000_0007, mepc=0x44, redirect_pc=0x21C.
- Priority: ext_irq, sw_irq and time_compare all pending with mie=0x888 → mcause=0x8000_000B; with exc_valid in the same cycle → the exception is taken instead.
- Masking: mstatus[3]=0 with mip=0x80 and mie=0x80 → no stall and no redirect for 20 cycles.
- mret: mepc=0x44, mstatus=0x80, mret pulse → N+1: csr_wdata=0x88; N+2: redirect_pc=0x44.
- Reset mid-sequence: resetn low during T_STAT → no redirect is issued, all outputs read 0, and the next exception is sequenced normally.
